// File: rtl/wire_shark_mem_pkg.sv
// Shared types and constants for the Wireshark capture on-chip memory subsystem.
package wire_shark_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 12;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = 4;
    localparam int unsigned MEM_RD_LAT = 1;

    typedef enum logic {
        M_NIOS = 1'b0,
        M_DMA  = 1'b1
    } master_id_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] address;
        logic [MEM_BE_W-1:0]   byteenable;
        logic                  read;
        logic                  write;
        logic [MEM_DATA_W-1:0] writedata;
        logic                  lock;
    } avm_req_t;

endpackage

// File: rtl/wire_shark_rd_return_pipe.sv
// Tracks accepted reads through the RAM latency and steers readdatavalid to the issuing master.
module wire_shark_rd_return_pipe
    import wire_shark_mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = MEM_RD_LAT,
    parameter int unsigned DATA_W       = MEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  master_id_t        owner_i,
    input  logic [DATA_W-1:0] mem_readdata_i,
    output logic [DATA_W-1:0] readdata_o,
    output logic              m0_valid_o,
    output logic              m1_valid_o
);

    logic [READ_LATENCY-1:0] valid_q;
    logic [READ_LATENCY-1:0] owner_q;

    // Async clear drops in-flight reads so no stale valid escapes after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q[0] <= load_i;
            owner_q[0] <= owner_i;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                owner_q[i] <= owner_q[i-1];
            end
        end
    end

    assign readdata_o = mem_readdata_i;
    assign m0_valid_o = valid_q[READ_LATENCY-1] && (owner_q[READ_LATENCY-1] == M_NIOS);
    assign m1_valid_o = valid_q[READ_LATENCY-1] && (owner_q[READ_LATENCY-1] == M_DMA);

endmodule

// File: rtl/wire_shark_onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter (Nios data master, capture DMA) in front of the on-chip RAM.
// Round-robin with an optional lock, capped by MAX_HOLD consecutive contended grants.
module wire_shark_onchip_mem_arbiter
    import wire_shark_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = MEM_ADDR_W,
    parameter int unsigned DATA_W       = MEM_DATA_W,
    parameter int unsigned BE_W         = MEM_BE_W,
    parameter int unsigned READ_LATENCY = MEM_RD_LAT,
    parameter int unsigned MAX_HOLD     = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [7:0] MAX_HOLD_CNT = 8'(MAX_HOLD);

    logic              m0_req;
    logic              m1_req;
    logic              gnt_valid;
    master_id_t        winner;
    logic              holder_lock;
    logic              other_req;

    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_write;
    logic              sel_lock;

    master_id_t        last_grant_q, last_grant_d;
    logic              locked_q, locked_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [DATA_W-1:0] rd_data;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

    // Gating with reset_n keeps both masters stalled while reset is held.
    always_comb begin
        gnt_valid   = 1'b0;
        winner      = M_NIOS;
        holder_lock = (last_grant_q == M_DMA) ? m1_lock : m0_lock;
        if (reset_n) begin
            if (m0_req && m1_req) begin
                gnt_valid = 1'b1;
                if (locked_q && holder_lock && (hold_cnt_q < MAX_HOLD_CNT)) begin
                    winner = last_grant_q;
                end else begin
                    winner = (last_grant_q == M_NIOS) ? M_DMA : M_NIOS;
                end
            end else if (m0_req) begin
                gnt_valid = 1'b1;
                winner    = M_NIOS;
            end else if (m1_req) begin
                gnt_valid = 1'b1;
                winner    = M_DMA;
            end
        end
    end

    assign sel_addr  = (winner == M_DMA) ? m1_address    : m0_address;
    assign sel_be    = (winner == M_DMA) ? m1_byteenable : m0_byteenable;
    assign sel_wdata = (winner == M_DMA) ? m1_writedata  : m0_writedata;
    assign sel_write = (winner == M_DMA) ? m1_write      : m0_write;
    assign sel_lock  = (winner == M_DMA) ? m1_lock       : m0_lock;
    assign other_req = (winner == M_DMA) ? m0_req        : m1_req;

    always_comb begin
        last_grant_d = last_grant_q;
        locked_d     = locked_q;
        hold_cnt_d   = hold_cnt_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        if (gnt_valid) begin
            last_grant_d = winner;
            locked_d     = sel_lock;
            addr_d       = sel_addr;
            be_d         = sel_be;
            wdata_d      = sel_wdata;
            // Counts only back-to-back wins that made the other master wait.
            if ((winner == last_grant_q) && other_req) begin
                hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
            end else begin
                hold_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= M_DMA;
            locked_q     <= 1'b0;
            hold_cnt_q   <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            locked_q     <= locked_d;
            hold_cnt_q   <= hold_cnt_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
        end
    end

    // Idle cycles keep the last driven address/data on the RAM bus.
    assign mem_chipselect = gnt_valid;
    assign mem_write      = gnt_valid & sel_write;
    assign mem_address    = gnt_valid ? sel_addr  : addr_q;
    assign mem_byteenable = gnt_valid ? sel_be    : be_q;
    assign mem_writedata  = gnt_valid ? sel_wdata : wdata_q;

    assign m0_waitrequest = !(gnt_valid && (winner == M_NIOS));
    assign m1_waitrequest = !(gnt_valid && (winner == M_DMA));

    wire_shark_rd_return_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_W       (DATA_W)
    ) u_rd_return_pipe (
        .clk_i          (clk),
        .rst_ni         (reset_n),
        .load_i         (gnt_valid & ~sel_write),
        .owner_i        (winner),
        .mem_readdata_i (mem_readdata),
        .readdata_o     (rd_data),
        .m0_valid_o     (m0_readdatavalid),
        .m1_valid_o     (m1_readdatavalid)
    );

    assign m0_readdata = rd_data;
    assign m1_readdata = rd_data;

endmodule
